bit_count_engine: RTL
=====================

Name: bit_count_engine

Overview:
- Parametrised successor to the lab's 8-bit ones-counter.
- Captures a DATA_W-bit word on a start request and computes one of four bit statistics: ones count, zeros count, leading-zero count or trailing-zero count.
- Examines CHUNK bits per clock and signals completion with a level done/start handshake.
- Sits between switch/register inputs and a hex display driver at top level, clocked from a divided clock.

Parameters:
DATA_W, 8, operand width; must be >= 2.
CHUNK, 1, bits examined per clock; 1 <= CHUNK <= DATA_W and DATA_W % CHUNK == 0, otherwise elaboration fails ($error).
CNT_W, $clog2(DATA_W+1), result width (derived; not overridden).

Ports:
clk  input  1  system clock, posedge.
reset  input  1  asynchronous, active-high reset.
start  input  1  level request; sampled only in IDLE and DONE.
mode  input  2  00 ones, 01 zeros, 10 leading zeros (from MSB), 11 trailing zeros (from LSB).
data  input  DATA_W  operand; captured on accepted start.
result  output  CNT_W  computed count; valid while done=1.
busy  output  1  high in COUNT.
done  output  1  high in DONE.

Behaviour:
- Reset (async, active-high): state=IDLE; result=0, busy=0, done=0; internal shift register, step counter and stop flag cleared. Reset takes effect mid-COUNT or in DONE with no completion.
- Let N = DATA_W/CHUNK.
- States: IDLE, COUNT, DONE.
- IDLE:
  - start=0: hold; result keeps its previous value.
  - start=1 at edge: capture data into shift register and mode into a mode register; clear result, step counter and stop flag; go to COUNT.
- COUNT: each edge processes one CHUNK, increments the step counter, and shifts the register by CHUNK. After the Nth COUNT edge, go to DONE. start, data and mode are ignored here.
  - mode 00: result += popcount(chunk). Chunk is taken from the LSB end; shift right.
  - mode 01: result += CHUNK - popcount(chunk).
  - mode 10: chunk is the top CHUNK bits, scanned MSB-first; shift left. Each 0 increments result until the first 1, which sets the stop flag. No increments after stop, across chunks too.
  - mode 11: same as mode 10, but the chunk is the low CHUNK bits, scanned LSB-first; shift right.
- DONE:
  - done=1 and result is stable.
  - start=1: stay in DONE.
  - start=0: go to IDLE next edge. done drops, result is held.
- Latency: start sampled at edge E0 gives busy high after E0 and done high after edge E0+N, so done is visible N+1 cycles after the request is presented. The value is identical for all modes; there is no early exit.
- If start falls during COUNT, the operation still completes. done is high for exactly one cycle, then the block returns to IDLE.
- Width rules:
  - Max result is DATA_W, which fits CNT_W.
  - An all-zero operand gives DATA_W for modes 01, 10 and 11, and 0 for mode 00.
  - An all-ones operand gives DATA_W for mode 00, and 0 for modes 01, 10 and 11.
- The block never accepts a new operand without passing through IDLE. Back-to-back requests need start low for at least one cycle.

Test Plan:
- DATA_W=8, CHUNK=1, mode 00, data=8'hFF, start held high: busy high for 8 cycles; done after 9th edge; result=8. Hold start 3 more cycles: done stays 1, result stays 8.
- Same configuration, then mode 00, data=8'hAA → result=4. Next operand mode 01, data=8'h38 → result=5. Changing data to 8'h00 during COUNT: result unaffected (still 5).
- Modes 10 and 11, DATA_W=8:
  - mode 10, data=8'h10 → result=3.
  - mode 11, data=8'h10 → result=4.
  - mode 10, data=8'h00 → result=8.
  - mode 11, data=8'h01 → result=0.
- DATA_W=16, CHUNK=4:
  - mode 00, data=16'hF0F1 → result=9; done after edge E0+4.
  - mode 10, data=16'h00F0 → result=8.
  - mode 11, data=16'h0100 → result=8.
- Reset mid-COUNT (assert reset between edges 3 and 4, asynchronous to clk): outputs go to 0 immediately without waiting for an edge; state=IDLE. A new start with 8'h0F in mode 00 then gives result=4 with normal latency.
- start dropped to 0 on the second COUNT cycle, DATA_W=8, data=8'h81, mode 00: done pulses exactly one cycle with result=2; IDLE follows; result stays 2 until the next accepted start.

Source files
------------

// File: rtl/bit_count_engine.sv
// Bit statistics engine: ones, zeros, leading-zero or trailing-zero count of a captured word, CHUNK bits per clock.
// Latency N=DATA_W/CHUNK edges after an accepted start; start is a level handshake, ignored while busy, and done holds until start drops.
module bit_count_engine #(
    parameter int DATA_W = 8,
    parameter int CHUNK  = 1,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  result,
    output logic              busy,
    output logic              done
);
    localparam int N      = DATA_W / CHUNK;
    localparam int STEP_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (DATA_W < 2 || CHUNK < 1 || CHUNK > DATA_W || (DATA_W % CHUNK) != 0) begin : g_param_check
        $error("bit_count_engine: illegal DATA_W/CHUNK combination");
    end

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [STEP_W-1:0]  step_q;
    logic               stop_q, stop_d;
    logic               last_step;
    logic [CHUNK-1:0]   lo_chunk, hi_chunk;

    assign last_step = (step_q == STEP_W'(N - 1));
    assign lo_chunk  = shreg_q[CHUNK-1:0];
    assign hi_chunk  = shreg_q[DATA_W-1 -: CHUNK];
    assign result    = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = COUNT;
            COUNT: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Leading/trailing scans stop at the first 1, and the stop flag carries that across chunks.
    always_comb begin
        result_d = result_q;
        stop_d   = stop_q;
        case (mode_q)
            2'b00: for (int i = 0; i < CHUNK; i++)
                       if (lo_chunk[i]) result_d = result_d + ONE;
            2'b01: for (int i = 0; i < CHUNK; i++)
                       if (!lo_chunk[i]) result_d = result_d + ONE;
            2'b10: for (int i = CHUNK - 1; i >= 0; i--) begin
                       if (hi_chunk[i])  stop_d   = 1'b1;
                       else if (!stop_d) result_d = result_d + ONE;
                   end
            default: for (int i = 0; i < CHUNK; i++) begin
                       if (lo_chunk[i])  stop_d   = 1'b1;
                       else if (!stop_d) result_d = result_d + ONE;
                   end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            mode_q   <= '0;
            result_q <= '0;
            step_q   <= '0;
            stop_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    shreg_q  <= data;
                    mode_q   <= mode;
                    result_q <= '0;
                    step_q   <= '0;
                    stop_q   <= 1'b0;
                end
                COUNT: begin
                    result_q <= result_d;
                    stop_q   <= stop_d;
                    step_q   <= step_q + STEP_W'(1);
                    shreg_q  <= (mode_q == 2'b10) ? (shreg_q << CHUNK) : (shreg_q >> CHUNK);
                end
                default: ;
            endcase
        end
    end
endmodule
